// File: rtl/pc_control_pkg.sv
// Shared types and default constants for the fetch-stage next-PC register.
// The select enum is what pc_next_sel decides and what pc_control registers on.
package pc_control_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_JUMP   = 2'd2,
    PC_SEL_HOLD   = 2'd3
  } pc_sel_t;

  localparam int          ADDR_W_DEF       = 32;
  localparam int          INCR_DEF         = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_control_next_sel.sv
// pc_next_sel: combinational priority encoder (stall > jumpReg > branch > sequential)
// plus the candidate-address mux. Holding is signalled through o_sel only.
module pc_next_sel
  import pc_control_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INCR   = INCR_DEF
) (
  input  logic              stall,
  input  logic              branch,
  input  logic              jumpReg,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] branchAddress,
  input  logic [ADDR_W-1:0] jumpAddress,
  output pc_sel_t           o_sel,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] INCR_W = ADDR_W'(INCR);

  // Wraps modulo 2^ADDR_W; the carry is intentionally discarded.
  logic [ADDR_W-1:0] w_seq_addr;
  assign w_seq_addr = PC + INCR_W;

  always_comb begin
    o_sel  = PC_SEL_SEQ;
    o_addr = w_seq_addr;
    if (stall) begin
      o_sel = PC_SEL_HOLD;
    end else if (jumpReg) begin
      o_sel  = PC_SEL_JUMP;
      o_addr = jumpAddress;
    end else if (branch) begin
      o_sel  = PC_SEL_BRANCH;
      o_addr = branchAddress;
    end
  end

endmodule

// File: rtl/pc_control.sv
// pc_control: registered next fetch address with synchronous active-low reset.
// Optional macro PC_CONTROL_ALIGN_CHECK_EN adds word-alignment of targets and a misaligned flag.
module pc_control
  import pc_control_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter int                INCR         = INCR_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              jumpReg,
  input  logic [ADDR_W-1:0] branchAddress,
  input  logic [ADDR_W-1:0] jumpAddress,
  input  logic [ADDR_W-1:0] PC,
`ifdef PC_CONTROL_ALIGN_CHECK_EN
  output logic              misaligned,
`endif
  output logic [ADDR_W-1:0] nextPC
);

  pc_sel_t           w_sel;
  logic [ADDR_W-1:0] w_cand;
  logic [ADDR_W-1:0] w_load;
  logic [ADDR_W-1:0] r_next_pc;

  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .INCR   (INCR)
  ) u_next_sel (
    .stall         (stall),
    .branch        (branch),
    .jumpReg       (jumpReg),
    .PC            (PC),
    .branchAddress (branchAddress),
    .jumpAddress   (jumpAddress),
    .o_sel         (w_sel),
    .o_addr        (w_cand)
  );

`ifdef PC_CONTROL_ALIGN_CHECK_EN
  logic w_is_target;
  logic r_misaligned;

  assign w_is_target = (w_sel == PC_SEL_BRANCH) || (w_sel == PC_SEL_JUMP);
  // Only redirect targets are word-aligned; the sequential path is left as-is.
  assign w_load      = w_is_target ? {w_cand[ADDR_W-1:2], 2'b00} : w_cand;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_misaligned <= 1'b0;
    end else if (w_sel != PC_SEL_HOLD) begin
      r_misaligned <= w_is_target && (w_cand[1:0] != 2'b00);
    end
  end

  assign misaligned = r_misaligned;
`else
  assign w_load = w_cand;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_next_pc <= RESET_VECTOR;
    end else if (w_sel != PC_SEL_HOLD) begin
      r_next_pc <= w_load;
    end
  end

  assign nextPC = r_next_pc;

endmodule

// File: tb/tb_pc_control.sv
// Directed plus random bench for pc_control; expected values come from a reference
// model, queued at drive time and popped after the clock edge.
module tb_pc_control;
  import pc_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jumpReg;
  logic [31:0] branchAddress, jumpAddress, PC;
  logic [31:0] nextPC;
`ifdef PC_CONTROL_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  pc_control dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .jumpReg       (jumpReg),
    .branchAddress (branchAddress),
    .jumpAddress   (jumpAddress),
    .PC            (PC),
`ifdef PC_CONTROL_ALIGN_CHECK_EN
    .misaligned    (misaligned),
`endif
    .nextPC        (nextPC)
  );

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc  = '0;
  logic        m_mis = 1'b0;
  bit          m_valid = 1'b0;

  task automatic step(input logic rst, input logic st, input logic br, input logic jr,
                      input logic [31:0] ba, input logic [31:0] ja, input logic [31:0] pc,
                      input string tag);
    exp_t        e;
    logic [31:0] tgt;
    reset = rst; stall = st; branch = br; jumpReg = jr;
    branchAddress = ba; jumpAddress = ja; PC = pc;
    #1;
    // New inputs must not reach nextPC before the edge.
    if (m_valid) begin
      n_assert++;
      assert (nextPC === m_pc) else begin
        n_fail++;
        $error("FAIL %s_pre_edge observed=%h expected=%h", tag, nextPC, m_pc);
      end
    end
    if (!rst) begin
      m_pc  = 32'h0;
      m_mis = 1'b0;
    end else if (!st) begin
      if (jr || br) begin
        tgt = jr ? ja : ba;
`ifdef PC_CONTROL_ALIGN_CHECK_EN
        m_mis = (tgt[1:0] != 2'b00);
        m_pc  = tgt & 32'hFFFF_FFFC;
`else
        m_mis = 1'b0;
        m_pc  = tgt;
`endif
      end else begin
        m_pc  = pc + 32'd4;
        m_mis = 1'b0;
      end
    end
    m_valid = 1'b1;
    e.pc  = m_pc;
    e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_assert++;
    assert (nextPC === e.pc) else begin
      n_fail++;
      $error("FAIL %s nextPC observed=%h expected=%h", tag, nextPC, e.pc);
    end
`ifdef PC_CONTROL_ALIGN_CHECK_EN
    n_assert++;
    assert (misaligned === e.mis) else begin
      n_fail++;
      $error("FAIL %s misaligned observed=%b expected=%b", tag, misaligned, e.mis);
    end
`endif
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch = 1'b0; jumpReg = 1'b0;
    branchAddress = '0; jumpAddress = '0; PC = '0;
    @(negedge clk);

    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,  32'h100, "reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0,   "seq_first");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h4,   "stall_1");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, "stall_rep");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd20, 32'h0,  32'h4,   "branch");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd20, 32'h0,  32'd20,  "seq_after_br");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'd40, 32'd24,  "jump");
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'd20, 32'd40, 32'd40,  "br_jr_prio");
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h60, 32'd40,  "br_jr_prio2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'h100, 32'h60, "stall_jr");
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'h60,  "stall_br");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'hFFFF_FFFC, "wrap");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'h1234_5670, "seq_mid");
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h300, 32'h8,  "reset_mid_stall");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd22, 32'h0,  32'h0,   "misaligned_br");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'd20,  "aligned_seq");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0000_0403, 32'd24, "misaligned_jr");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h400, "mis_hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'h400, "mis_reset");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] rb, rj, rp;
      rb = $urandom; rj = $urandom; rp = $urandom;
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           rb, rj, rp, "random");
    end

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
